bcd_result_display_scanner: RTL and testbench
=============================================

Name: bcd_result_display_scanner

Overview:
- Consumes the signed single-digit result of the BCD subtractor (magnitude digit + SignPositive flag) and drives a 4-digit time-multiplexed seven-segment display.
- Digit0 shows the magnitude, digit1 shows the sign, and digits 3..2 show a BCD count (00-99) of results captured since reset or clear.
- Sits directly downstream of the subtractor, between it and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (legal range >= 1)
- CNT_W, 17, width of the refresh counter; must hold REFRESH_DIV-1

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- result_valid  input  1  one-cycle strobe; capture result this cycle
- result_digit  input  4  BCD magnitude from subtractor
- result_sign_positive  input  1  1 = result >= 0, 0 = negative
- clear  input  1  synchronous clear of held result and count
- seg  output  7  segments a..g, bit6 = a, 1 = lit
- an_n  output  4  digit enables, one-hot active-low, bit0 = digit0
- result_count  output  8  two BCD digits {tens, units} of captured results

Behaviour:
- One clock (clk) domain; reset is synchronous and active-low (rst_n). All state changes happen on the rising edge of clk.
- Priority: rst_n low > clear > result_valid.
- Reset values: held_digit = 0, held_sign_pos = 1, result_count = 8'h00, refresh counter = 0, scan_idx = 0, an_n = 4'b1110, seg = 7'b1111110 ('0').
- Capture: when result_valid = 1 (and no clear), latch result_digit and result_sign_positive. result_count increments in BCD: units 9 -> 0 with tens carry; 8'h99 -> 8'h00 (wrap, no flag).
- Negative zero: digit = 0 with sign_positive = 0 is stored as positive zero.
- clear = 1: held_digit = 0, held_sign_pos = 1, result_count = 8'h00. Refresh and scan state are unaffected. If clear and valid occur in the same cycle, clear wins and the valid strobe is dropped.
- Refresh counter: counts 0..REFRESH_DIV-1. On the terminal count it wraps to 0 and scan_idx advances 0->1->2->3->0. With REFRESH_DIV = 1, scan_idx advances every cycle.
- Output registers: each cycle, an_n and seg are loaded from the current scan_idx and held state. Outputs therefore lag scan_idx and captures by exactly 1 cycle; an_n and seg always change on the same edge.
- Digit content:
  - idx0: decode(held_digit).
  - idx1: 7'b0000001 ('-', g only) if negative, else 7'b0000000.
  - idx2: decode(count units).
  - idx3: decode(count tens).
- Decode table: 0-9 use the team standard abcdefg patterns; codes 10-15 give 7'b0000000 (blank). An illegal held_digit is held and blanked, and the count still increments.
- result_valid on consecutive cycles: every strobe is captured and counted.
- Captures never disturb scan timing.

Decomposition:
- Shared package holds:
  - segment constants SEG_BLANK = 7'b0000000, SEG_MINUS = 7'b0000001;
  - the 0-9 pattern constants;
  - ANODE_IDLE = 4'b1111.
- One combinational sub-module, seg7_decode (4-bit BCD in, 7-bit segments out, blank default), instantiated once on the muxed digit.
- The BCD counter increment stays inline.

Test Plan:
- Reset: rst_n = 0 for 3 cycles, then release with REFRESH_DIV = 4 -> an_n = 1110 and seg = 1111110 immediately after reset. an_n steps 1101, 1011, 0111, 1110, changing every 4 cycles.
- Capture: result_valid with digit = 7, sign_positive = 0 -> digit0 slot shows 7'b1110000, digit1 slot shows 7'b0000001, result_count = 8'h01.
- Negative zero: capture digit = 0, sign_positive = 0 -> digit1 slot blank, digit0 slot 7'b1111110.
- Count wrap: 100 back-to-back valid strobes -> result_count goes 8'h09 -> 8'h10 and 8'h99 -> 8'h00. Tens slot shows '1' after the 10th strobe.
- Priority: clear and result_valid (digit = 5) in the same cycle when count = 8'h42 -> count = 8'h00, held_digit = 0. A mid-scan rst_n pulse returns an_n to 1110 on the next edge.
- Illegal input: capture digit = 4'hC -> digit0 slot seg = 7'b0000000, count increments. With REFRESH_DIV = 1, an_n rotates every cycle.

Source files
------------

// File: rtl/bcd_result_display_scanner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_result_display_scanner_pkg : segment patterns and scan slot encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package bcd_result_display_scanner_pkg;

  // Segment order is abcdefg with bit6 = a; 1 = lit
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

  localparam logic [3:0] ANODE_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN_MAG   = 2'd0,
    SCAN_SIGN  = 2'd1,
    SCAN_UNITS = 2'd2,
    SCAN_TENS  = 2'd3
  } scan_idx_t;

endpackage
`default_nettype wire

// File: rtl/bcd_result_display_scanner_seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode : BCD digit to abcdefg segments, codes 10-15 blank
// Rev 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import bcd_result_display_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_result_display_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_result_display_scanner : holds signed subtractor result + BCD capture count
// and scans them onto a 4-digit multiplexed seven-segment display. Rev 1.0
// ----------------------------------------------------------------------------
module bcd_result_display_scanner
  import bcd_result_display_scanner_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       result_valid,
  input  logic [3:0] result_digit,
  input  logic       result_sign_positive,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] an_n,
  output logic [7:0] result_count
);

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] refresh_cnt;
  scan_idx_t        scan_idx;
  logic [3:0]       held_digit;
  logic             held_sign_pos;
  logic [7:0]       next_count;
  logic [3:0]       mux_digit;
  logic [6:0]       digit_seg;
  logic [6:0]       next_seg;
  logic [3:0]       next_an;

  always_comb begin
    next_count = result_count;
    if (result_count[3:0] == 4'd9) begin
      next_count[3:0] = 4'd0;
      next_count[7:4] = (result_count[7:4] == 4'd9) ? 4'd0 : result_count[7:4] + 4'd1;
    end else begin
      next_count[3:0] = result_count[3:0] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_digit    <= 4'd0;
      held_sign_pos <= 1'b1;
      result_count  <= 8'h00;
    end else if (clear) begin
      held_digit    <= 4'd0;
      held_sign_pos <= 1'b1;
      result_count  <= 8'h00;
    end else if (result_valid) begin
      held_digit    <= result_digit;
      // A zero magnitude is always shown unsigned, never as "-0"
      held_sign_pos <= result_sign_positive | (result_digit == 4'd0);
      result_count  <= next_count;
    end
  end

  always_comb begin
    mux_digit = held_digit;
    case (scan_idx)
      SCAN_UNITS: mux_digit = result_count[3:0];
      SCAN_TENS:  mux_digit = result_count[7:4];
      default:    mux_digit = held_digit;
    endcase
  end

  seg7_decode u_decode (
    .bcd (mux_digit),
    .seg (digit_seg)
  );

  always_comb begin
    next_seg = digit_seg;
    if (scan_idx == SCAN_SIGN) begin
      next_seg = held_sign_pos ? SEG_BLANK : SEG_MINUS;
    end
    next_an           = ANODE_IDLE;
    next_an[scan_idx] = 1'b0;
  end

  // Outputs are registered from the current slot, so they trail scan_idx by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= SCAN_MAG;
      an_n        <= 4'b1110;
      seg         <= SEG_0;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        scan_idx    <= scan_idx_t'(scan_idx + 2'd1);
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      an_n <= next_an;
      seg  <= next_seg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_result_display_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bcd_result_display_scanner : directed self-checking bench. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_result_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       result_valid = 1'b0;
  logic [3:0] result_digit = 4'd0;
  logic       result_sign_positive = 1'b1;
  logic       clear = 1'b0;
  logic [6:0] seg, seg_f;
  logic [3:0] an_n, an_n_f;
  logic [7:0] result_count, result_count_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_result_display_scanner #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .result_valid         (result_valid),
    .result_digit         (result_digit),
    .result_sign_positive (result_sign_positive),
    .clear                (clear),
    .seg                  (seg),
    .an_n                 (an_n),
    .result_count         (result_count)
  );

  bcd_result_display_scanner #(.REFRESH_DIV(1), .CNT_W(1)) dut_fast (
    .clk                  (clk),
    .rst_n                (rst_n),
    .result_valid         (result_valid),
    .result_digit         (result_digit),
    .result_sign_positive (result_sign_positive),
    .clear                (clear),
    .seg                  (seg_f),
    .an_n                 (an_n_f),
    .result_count         (result_count_f)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances at least one cycle, then until the slot is displayed (bounded)
  task automatic wait_slot(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an_n === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic strobe(input logic [3:0] d, input logic sp);
    result_digit         = d;
    result_sign_positive = sp;
    result_valid         = 1'b1;
    step();
    result_valid         = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    n_cmp++;
    if (an_n !== 4'b1110) begin n_err++; $display("FAIL reset_an_n: got %b want 1110", an_n); end
    n_cmp++;
    if (seg !== 7'b1111110) begin n_err++; $display("FAIL reset_seg: got %b want 1111110", seg); end
    n_cmp++;
    if (result_count !== 8'h00) begin n_err++; $display("FAIL reset_count: got %h want 00", result_count); end
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_an = ~(4'b0001 << (((i - 1) / 4) % 4));
      n_cmp++;
      if (an_n !== exp_an) begin
        n_err++;
        $display("FAIL scan_an_n cycle %0d: got %b want %b", i, an_n, exp_an);
      end
    end
  endtask

  task automatic test_capture();
    bit ok;
    strobe(4'd7, 1'b0);
    n_cmp++;
    if (result_count !== 8'h01) begin n_err++; $display("FAIL capture_count: got %h want 01", result_count); end
    wait_slot(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== 7'b1110000) begin n_err++; $display("FAIL capture_digit0 (slot_found=%0d): got %b want 1110000", ok, seg); end
    wait_slot(4'b1101, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0000001) begin n_err++; $display("FAIL capture_sign (slot_found=%0d): got %b want 0000001", ok, seg); end
    wait_slot(4'b1011, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0110000) begin n_err++; $display("FAIL capture_units (slot_found=%0d): got %b want 0110000", ok, seg); end
    wait_slot(4'b0111, ok);
    n_cmp++;
    if (!ok || seg !== 7'b1111110) begin n_err++; $display("FAIL capture_tens (slot_found=%0d): got %b want 1111110", ok, seg); end
  endtask

  task automatic test_neg_zero();
    bit ok;
    strobe(4'd0, 1'b0);
    n_cmp++;
    if (result_count !== 8'h02) begin n_err++; $display("FAIL negzero_count: got %h want 02", result_count); end
    wait_slot(4'b1101, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0000000) begin n_err++; $display("FAIL negzero_sign (slot_found=%0d): got %b want 0000000", ok, seg); end
    wait_slot(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== 7'b1111110) begin n_err++; $display("FAIL negzero_digit0 (slot_found=%0d): got %b want 1111110", ok, seg); end
  endtask

  task automatic test_count_wrap();
    bit ok;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++;
    if (result_count !== 8'h00) begin n_err++; $display("FAIL clear_count: got %h want 00", result_count); end
    result_digit         = 4'd3;
    result_sign_positive = 1'b1;
    result_valid         = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 9) begin
        n_cmp++;
        if (result_count !== 8'h09) begin n_err++; $display("FAIL wrap_count9: got %h want 09", result_count); end
      end else if (k == 10) begin
        n_cmp++;
        if (result_count !== 8'h10) begin n_err++; $display("FAIL wrap_count10: got %h want 10", result_count); end
      end else if (k == 55) begin
        n_cmp++;
        if (result_count !== 8'h55) begin n_err++; $display("FAIL wrap_count55: got %h want 55", result_count); end
      end else if (k == 99) begin
        n_cmp++;
        if (result_count !== 8'h99) begin n_err++; $display("FAIL wrap_count99: got %h want 99", result_count); end
      end else if (k == 100) begin
        n_cmp++;
        if (result_count !== 8'h00) begin n_err++; $display("FAIL wrap_count100: got %h want 00", result_count); end
      end
    end
    result_valid = 1'b0;
    for (int k = 0; k < 10; k++) strobe(4'd3, 1'b1);
    n_cmp++;
    if (result_count !== 8'h10) begin n_err++; $display("FAIL tens_count: got %h want 10", result_count); end
    wait_slot(4'b0111, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0110000) begin n_err++; $display("FAIL tens_slot (slot_found=%0d): got %b want 0110000", ok, seg); end
    wait_slot(4'b1011, ok);
    n_cmp++;
    if (!ok || seg !== 7'b1111110) begin n_err++; $display("FAIL units_slot (slot_found=%0d): got %b want 1111110", ok, seg); end
  endtask

  task automatic test_priority();
    bit ok;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 42; k++) strobe(4'd1, 1'b0);
    n_cmp++;
    if (result_count !== 8'h42) begin n_err++; $display("FAIL prio_precount: got %h want 42", result_count); end
    clear                = 1'b1;
    result_valid         = 1'b1;
    result_digit         = 4'd5;
    result_sign_positive = 1'b1;
    step();
    clear        = 1'b0;
    result_valid = 1'b0;
    n_cmp++;
    if (result_count !== 8'h00) begin n_err++; $display("FAIL prio_count: got %h want 00", result_count); end
    wait_slot(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== 7'b1111110) begin n_err++; $display("FAIL prio_digit0 (slot_found=%0d): got %b want 1111110", ok, seg); end
    wait_slot(4'b1101, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0000000) begin n_err++; $display("FAIL prio_sign (slot_found=%0d): got %b want 0000000", ok, seg); end
    wait_slot(4'b1011, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL midscan_slot: got %b want 1011", an_n); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (an_n !== 4'b1110) begin n_err++; $display("FAIL midscan_reset_an_n: got %b want 1110", an_n); end
    n_cmp++;
    if (seg !== 7'b1111110) begin n_err++; $display("FAIL midscan_reset_seg: got %b want 1111110", seg); end
  endtask

  task automatic test_illegal();
    bit ok;
    strobe(4'hC, 1'b1);
    n_cmp++;
    if (result_count !== 8'h01) begin n_err++; $display("FAIL illegal_count: got %h want 01", result_count); end
    wait_slot(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0000000) begin n_err++; $display("FAIL illegal_digit0 (slot_found=%0d): got %b want 0000000", ok, seg); end
    wait_slot(4'b1011, ok);
    n_cmp++;
    if (!ok || seg !== 7'b0110000) begin n_err++; $display("FAIL illegal_units (slot_found=%0d): got %b want 0110000", ok, seg); end
  endtask

  task automatic test_fast_scan();
    logic [3:0] exp_an;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (an_n_f !== 4'b1110) begin n_err++; $display("FAIL fast_reset_an_n: got %b want 1110", an_n_f); end
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_an = ~(4'b0001 << ((i - 1) % 4));
      n_cmp++;
      if (an_n_f !== exp_an) begin
        n_err++;
        $display("FAIL fast_an_n cycle %0d: got %b want %b", i, an_n_f, exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_neg_zero();
    test_count_wrap();
    test_priority();
    test_illegal();
    test_fast_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
